// File: rtl/aes_spi_host.sv
// SPI host for an external AES engine. It shifts {key, message} out in one frame,
// waits for the slave to signal readiness, then reads the 128-bit result back.
module aes_spi_host #(
  parameter int Nk          = 4,
  parameter int HALF_DIV    = 2,
  parameter int WAIT_CYCLES = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [Nk*32-1:0]   key,
  input  logic [127:0]       message,
  output logic [127:0]       result,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               sclk,
  output logic               cs,
  output logic               sdo,
  input  logic               sdi,
  input  logic               slave_ready,
  output logic [2:0]         dbg_state
);

  // Handshake: start is a single-cycle request honoured only in IDLE; busy is high
  // from the accepting edge until FIN, where done (and error on timeout) pulse
  // for exactly one cycle while busy is already low.

  localparam int LOAD_BITS = 128 + Nk * 32;
  localparam int READ_BITS = 128;
  // GAP opens with a 2*HALF_DIV quiet guard of cs low before the wait count runs.
  // Together with the HALF_DIV lead-in and tail of each frame and the one-cycle
  // FIN, the latency from accepted start to done is
  //   2*HALF_DIV*LOAD_BITS + 2*HALF_DIV*128 + max(WAIT_CYCLES, ready) + 4*HALF_DIV + 2.
  localparam int GAP_MIN   = 2 * HALF_DIV + WAIT_CYCLES;
  localparam int GAP_TOP   = (GAP_MIN > TIMEOUT) ? GAP_MIN : TIMEOUT;
  localparam int BW        = $clog2(LOAD_BITS + 1);
  localparam int DW        = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int GW        = $clog2(GAP_TOP + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_GAP  = 3'd2,
    S_READ = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   sclk_q, sclk_d;
  logic                   err_q, err_d;
  logic [LOAD_BITS-1:0]   shift_q, shift_d;
  logic [READ_BITS-1:0]   rx_q, rx_d;
  logic [READ_BITS-1:0]   result_q, result_d;

  logic [BW-1:0]          frame_bits;
  logic                   tick;
  logic                   frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      sclk_q   <= 1'b0;
      err_q    <= 1'b0;
      shift_q  <= '0;
      rx_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      sclk_q   <= sclk_d;
      err_q    <= err_d;
      shift_q  <= shift_d;
      rx_q     <= rx_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    sclk_d     = sclk_q;
    err_d      = err_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    result_d   = result_q;
    frame_bits = (state_q == S_LOAD) ? BW'(LOAD_BITS) : BW'(READ_BITS);
    tick       = (div_q == DW'(HALF_DIV - 1));
    // bit_q counts falling edges, so equality means the last bit's falling edge is done
    frame_end  = (bit_q == frame_bits);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          shift_d = {key, message};
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      S_LOAD, S_READ: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          if (frame_end) begin
            bit_d = '0;
            if (state_q == S_LOAD) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              state_d  = S_FIN;
              result_d = rx_q;
            end
          end else begin
            sclk_d = ~sclk_q;
            if (sclk_q) begin
              bit_d = bit_q + 1'b1;
              if (state_q == S_LOAD) shift_d = {1'b0, shift_q[LOAD_BITS-1:1]};
            end else if (state_q == S_READ) begin
              // first sample ends up in bit 0 after 128 right shifts
              rx_d = {sdi, rx_q[READ_BITS-1:1]};
            end
          end
        end
      end

      S_GAP: begin
        if ((gap_q >= GW'(GAP_MIN)) && slave_ready) begin
          state_d = S_READ;
          div_d   = '0;
          bit_d   = '0;
        end else if (gap_q == GW'(TIMEOUT - 1)) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cs        = (state_q == S_LOAD) || (state_q == S_READ);
  assign sclk      = sclk_q;
  assign sdo       = (state_q == S_LOAD) & shift_q[0];
  assign busy      = (state_q == S_LOAD) || (state_q == S_GAP) || (state_q == S_READ);
  assign done      = (state_q == S_FIN);
  assign error     = (state_q == S_FIN) & err_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_spi_host.sv
// Bench for aes_spi_host: instance A (Nk=4, HALF_DIV=2) and instance B (Nk=8,
// HALF_DIV=1, WAIT_CYCLES=0), each with a behavioural SPI slave.
`timescale 1ns/1ps
module tb_aes_spi_host;

  localparam int NK_A = 4, HD_A = 2, WT_A = 16, TO_A = 64;
  localparam int NK_B = 8, HD_B = 1, WT_B = 0,  TO_B = 64;
  localparam int LOAD_A = 128 + NK_A * 32;
  localparam int LOAD_B = 128 + NK_B * 32;
  localparam int LAT_A  = 2*HD_A*LOAD_A + 2*HD_A*128 + WT_A + 4*HD_A + 2;
  localparam int LAT_B  = 2*HD_B*LOAD_B + 2*HD_B*128 + WT_B + 4*HD_B + 2;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_GAP = 3'd2, ST_READ = 3'd3;
  localparam logic [127:0] MSG0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] KEY0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] RSP0 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start_a, sdi_a, slave_ready_a;
  logic [127:0]     key_a, msg_a, result_a;
  logic             busy_a, done_a, error_a, sclk_a, cs_a, sdo_a;
  logic [2:0]       state_a;
  logic             start_b, sdi_b, slave_ready_b;
  logic [255:0]     key_b;
  logic [127:0]     msg_b, result_b;
  logic             busy_b, done_b, error_b, sclk_b, cs_b, sdo_b;
  logic [2:0]       state_b;

  int tests = 0;
  int fails = 0;

  logic         exp_bits_a[$], exp_bits_b[$], got_a[$], got_b[$];
  logic [127:0] exp_res_a[$], exp_res_b[$];
  logic [127:0] rsp_a, rsp_b;
  logic         ready_en_a, ready_en_b;
  int           load_rises_a = 0, read_rises_a = 0, rd_idx_a = 0;
  int           load_rises_b = 0, read_rises_b = 0, rd_idx_b = 0;
  logic         sclk_prev_a = 1'b0, sclk_prev_b = 1'b0;

  aes_spi_host #(.Nk(NK_A), .HALF_DIV(HD_A), .WAIT_CYCLES(WT_A), .TIMEOUT(TO_A)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .key(key_a), .message(msg_a),
    .result(result_a), .busy(busy_a), .done(done_a), .error(error_a),
    .sclk(sclk_a), .cs(cs_a), .sdo(sdo_a), .sdi(sdi_a),
    .slave_ready(slave_ready_a), .dbg_state(state_a)
  );

  aes_spi_host #(.Nk(NK_B), .HALF_DIV(HD_B), .WAIT_CYCLES(WT_B), .TIMEOUT(TO_B)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .key(key_b), .message(msg_b),
    .result(result_b), .busy(busy_b), .done(done_b), .error(error_b),
    .sclk(sclk_b), .cs(cs_b), .sdo(sdo_b), .sdi(sdi_b),
    .slave_ready(slave_ready_b), .dbg_state(state_b)
  );

  // ---------------- slave models (sampled 1ns after the clock edge) ----------------
  always @(posedge clk) begin
    #1;
    if (state_a == ST_IDLE) begin load_rises_a = 0; read_rises_a = 0; end
    if (sclk_a && !sclk_prev_a) begin
      if (state_a == ST_LOAD) begin got_a.push_back(sdo_a); load_rises_a++; end
      else if (state_a == ST_READ) read_rises_a++;
    end
    if (state_a != ST_READ) rd_idx_a = 0;
    else if (!sclk_a && sclk_prev_a && rd_idx_a < 127) rd_idx_a++;
    sdi_a = rsp_a[rd_idx_a];
    slave_ready_a = ready_en_a && (load_rises_a == LOAD_A);
    sclk_prev_a = sclk_a;
  end

  always @(posedge clk) begin
    #1;
    if (state_b == ST_IDLE) begin load_rises_b = 0; read_rises_b = 0; end
    if (sclk_b && !sclk_prev_b) begin
      if (state_b == ST_LOAD) begin got_b.push_back(sdo_b); load_rises_b++; end
      else if (state_b == ST_READ) read_rises_b++;
    end
    if (state_b != ST_READ) rd_idx_b = 0;
    else if (!sclk_b && sclk_prev_b && rd_idx_b < 127) rd_idx_b++;
    sdi_b = rsp_b[rd_idx_b];
    slave_ready_b = ready_en_b && (load_rises_b == LOAD_B);
    sclk_prev_b = sclk_b;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_exp(input int sel, input logic [255:0] k, input logic [127:0] m);
    if (sel == 0) begin
      for (int i = 0; i < 128; i++) exp_bits_a.push_back(m[i]);
      for (int i = 0; i < NK_A*32; i++) exp_bits_a.push_back(k[i]);
    end else begin
      for (int i = 0; i < 128; i++) exp_bits_b.push_back(m[i]);
      for (int i = 0; i < NK_B*32; i++) exp_bits_b.push_back(k[i]);
    end
  endtask

  // start sampled on the posedge between the two negedges; returns after that edge
  task automatic start_xfer(input int sel, input logic [255:0] k, input logic [127:0] m);
    @(negedge clk);
    if (sel == 0) begin key_a = k[127:0]; msg_a = m; start_a = 1'b1; end
    else          begin key_b = k;        msg_b = m; start_b = 1'b1; end
    push_exp(sel, k, m);
    @(negedge clk);
    if (sel == 0) begin start_a = 1'b0; key_a = ~k[127:0]; msg_a = ~m; end
    else          begin start_b = 1'b0; key_b = ~k;        msg_b = ~m; end
  endtask

  // cyc = latency in cycles when done is seen; res_moved flags a result change before done
  task automatic wait_done(input int sel, input int budget, output int cyc,
                           output bit seen, output bit res_moved);
    logic [127:0] r0;
    r0 = (sel == 0) ? result_a : result_b;
    cyc = 1; seen = 1'b0; res_moved = 1'b0;
    while (cyc <= budget) begin
      if (((sel == 0) ? done_a : done_b) === 1'b1) begin seen = 1'b1; break; end
      if (((sel == 0) ? result_a : result_b) !== r0) res_moved = 1'b1;
      @(negedge clk);
      cyc++;
    end
  endtask

  // pops n captured and n expected bits, returns how many disagree or were missing
  task automatic diff_bits(input int sel, input int n, output int nbad);
    logic g, e;
    nbad = 0;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin
        if (got_a.size() == 0 || exp_bits_a.size() == 0) begin nbad += n - i; break; end
        g = got_a.pop_front(); e = exp_bits_a.pop_front();
      end else begin
        if (got_b.size() == 0 || exp_bits_b.size() == 0) begin nbad += n - i; break; end
        g = got_b.pop_front(); e = exp_bits_b.pop_front();
      end
      if (g !== e) nbad++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({cs_a, sclk_a, sdo_a, busy_a, done_a, error_a} !== 6'b0) begin
      fails++; $display("FAIL reset_outs_a: got %b, required 000000", {cs_a, sclk_a, sdo_a, busy_a, done_a, error_a});
    end
    tests++;
    if (result_a !== 128'h0) begin fails++; $display("FAIL reset_result_a: got %h, required 0", result_a); end
    tests++;
    if ({cs_b, sclk_b, sdo_b, busy_b, done_b, error_b} !== 6'b0) begin
      fails++; $display("FAIL reset_outs_b: got %b, required 000000", {cs_b, sclk_b, sdo_b, busy_b, done_b, error_b});
    end
    tests++;
    if (result_b !== 128'h0) begin fails++; $display("FAIL reset_result_b: got %h, required 0", result_b); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (state_a !== ST_IDLE || busy_a !== 1'b0) begin
      fails++; $display("FAIL reset_release_a: state %0d busy %b, required 0 0", state_a, busy_a);
    end
  endtask

  task automatic test_load_read();
    int cyc, nbad; bit seen, moved; logic [127:0] er;
    ready_en_a = 1'b1; rsp_a = RSP0;
    start_xfer(0, {128'h0, KEY0}, MSG0);
    exp_res_a.push_back(RSP0);
    tests++;
    if (busy_a !== 1'b1) begin fails++; $display("FAIL busy_after_start: got %b, required 1", busy_a); end
    wait_done(0, LAT_A + 200, cyc, seen, moved);
    tests++;
    if (seen !== 1'b1 || cyc !== LAT_A) begin fails++; $display("FAIL latency_a: got %0d (seen %b), required %0d", cyc, seen, LAT_A); end
    tests++;
    if (error_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL fin_flags_a: error %b busy %b, required 0 0", error_a, busy_a); end
    er = exp_res_a.pop_front();
    tests++;
    if (result_a !== er) begin fails++; $display("FAIL result_a: got %h, required %h", result_a, er); end
    tests++;
    if (moved !== 1'b0) begin fails++; $display("FAIL result_partial: got %b, required 0", moved); end
    tests++;
    if (load_rises_a !== LOAD_A || read_rises_a !== 128) begin
      fails++; $display("FAIL edges_a: load %0d read %0d, required %0d 128", load_rises_a, read_rises_a, LOAD_A);
    end
    diff_bits(0, LOAD_A, nbad);
    tests++;
    if (nbad !== 0) begin fails++; $display("FAIL load_bits_a: got %0d bad bits, required 0", nbad); end
    @(negedge clk);
    tests++;
    if (done_a !== 1'b0) begin fails++; $display("FAIL done_single_a: got %b, required 0", done_a); end
  endtask

  task automatic test_timeout();
    int n, nbad; logic [127:0] er;
    ready_en_a = 1'b0;
    start_xfer(0, {128'h0, rand128()}, rand128());
    exp_res_a.push_back(RSP0);
    n = 0;
    while (state_a !== ST_GAP && n < 2*HD_A*LOAD_A + 100) begin @(negedge clk); n++; end
    tests++;
    if (state_a !== ST_GAP) begin fails++; $display("FAIL gap_entry: state %0d, required %0d", state_a, ST_GAP); end
    n = 0;
    while (done_a !== 1'b1 && n < TO_A + 50) begin @(negedge clk); n++; end
    tests++;
    if (n !== TO_A || error_a !== 1'b1) begin fails++; $display("FAIL timeout: cycles %0d error %b, required %0d 1", n, error_a, TO_A); end
    er = exp_res_a.pop_front();
    tests++;
    if (result_a !== er) begin fails++; $display("FAIL timeout_result: got %h, required %h", result_a, er); end
    tests++;
    if (read_rises_a !== 0) begin fails++; $display("FAIL timeout_no_read: got %0d, required 0", read_rises_a); end
    diff_bits(0, LOAD_A, nbad);
    tests++;
    if (nbad !== 0) begin fails++; $display("FAIL timeout_load_bits: got %0d bad bits, required 0", nbad); end
    @(negedge clk);
    tests++;
    if ({done_a, error_a} !== 2'b00) begin fails++; $display("FAIL timeout_pulse: got %b, required 00", {done_a, error_a}); end
    ready_en_a = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    int n, cyc, nbad; bit seen, moved; logic [127:0] er;
    rsp_a = rand128();
    start_xfer(0, {128'h0, rand128()}, rand128());
    n = 0;
    while (load_rises_a < 100 && n < 2000) begin @(negedge clk); n++; end
    rst = 1'b1;
    #1;
    tests++;
    if ({cs_a, sclk_a, busy_a} !== 3'b000 || state_a !== ST_IDLE) begin
      fails++; $display("FAIL async_reset: cs/sclk/busy %b state %0d, required 000 0", {cs_a, sclk_a, busy_a}, state_a);
    end
    @(negedge clk);
    tests++;
    if (done_a !== 1'b0 || result_a !== 128'h0) begin fails++; $display("FAIL abort: done %b result %h, required 0 0", done_a, result_a); end
    rst = 1'b0;
    tests++;
    if (got_a.size() !== 100) begin fails++; $display("FAIL abort_bits: got %0d bits, required 100", got_a.size()); end
    diff_bits(0, 100, nbad);
    tests++;
    if (nbad !== 0) begin fails++; $display("FAIL abort_bit_values: got %0d bad bits, required 0", nbad); end
    exp_bits_a.delete();
    got_a.delete();
    rsp_a = rand128();
    start_xfer(0, {128'h0, rand128()}, rand128());
    exp_res_a.push_back(rsp_a);
    wait_done(0, LAT_A + 200, cyc, seen, moved);
    tests++;
    if (seen !== 1'b1 || cyc !== LAT_A || load_rises_a !== LOAD_A) begin
      fails++; $display("FAIL restart: latency %0d edges %0d, required %0d %0d", cyc, load_rises_a, LAT_A, LOAD_A);
    end
    diff_bits(0, LOAD_A, nbad);
    tests++;
    if (nbad !== 0) begin fails++; $display("FAIL restart_bits: got %0d bad bits, required 0", nbad); end
    er = exp_res_a.pop_front();
    tests++;
    if (result_a !== er) begin fails++; $display("FAIL restart_result: got %h, required %h", result_a, er); end
  endtask

  task automatic test_back_to_back();
    int cyc, nbad; bit seen, moved; logic [127:0] er, m2;
    logic [255:0] k2;
    ready_en_b = 1'b1; rsp_b = rand128();
    start_xfer(1, {rand128(), rand128()}, rand128());
    exp_res_b.push_back(rsp_b);
    cyc = 1;
    while (done_b !== 1'b1 && cyc <= LAT_B + 200) begin
      start_b = (cyc % 300 == 50);
      @(negedge clk);
      cyc++;
    end
    start_b = 1'b0;
    tests++;
    if (cyc !== LAT_B) begin fails++; $display("FAIL latency_b: got %0d, required %0d", cyc, LAT_B); end
    tests++;
    if (load_rises_b !== LOAD_B || read_rises_b !== 128) begin
      fails++; $display("FAIL edges_b: load %0d read %0d, required %0d 128", load_rises_b, read_rises_b, LOAD_B);
    end
    er = exp_res_b.pop_front();
    tests++;
    if (result_b !== er || error_b !== 1'b0) begin fails++; $display("FAIL result_b: got %h err %b, required %h 0", result_b, error_b, er); end
    diff_bits(1, LOAD_B, nbad);
    tests++;
    if (nbad !== 0) begin fails++; $display("FAIL load_bits_b: got %0d bad bits, required 0", nbad); end
    // start raised in the FIN cycle and held into the following IDLE cycle
    k2 = {rand128(), rand128()}; m2 = rand128();
    key_b = k2; msg_b = m2; start_b = 1'b1;
    @(negedge clk);
    tests++;
    if (state_b !== ST_IDLE || busy_b !== 1'b0 || done_b !== 1'b0) begin
      fails++; $display("FAIL fin_start_ignored: state %0d busy %b done %b, required 0 0 0", state_b, busy_b, done_b);
    end
    push_exp(1, k2, m2);
    rsp_b = rand128();
    exp_res_b.push_back(rsp_b);
    @(negedge clk);
    start_b = 1'b0; key_b = ~k2; msg_b = ~m2;
    tests++;
    if (state_b !== ST_LOAD || busy_b !== 1'b1) begin
      fails++; $display("FAIL idle_start_accepted: state %0d busy %b, required 1 1", state_b, busy_b);
    end
    wait_done(1, LAT_B + 200, cyc, seen, moved);
    tests++;
    if (seen !== 1'b1 || cyc !== LAT_B) begin fails++; $display("FAIL latency_b2: got %0d (seen %b), required %0d", cyc, seen, LAT_B); end
    diff_bits(1, LOAD_B, nbad);
    tests++;
    if (nbad !== 0) begin fails++; $display("FAIL load_bits_b2: got %0d bad bits, required 0", nbad); end
    er = exp_res_b.pop_front();
    tests++;
    if (result_b !== er) begin fails++; $display("FAIL result_b2: got %h, required %h", result_b, er); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    start_a = 1'b0; key_a = '0; msg_a = '0; ready_en_a = 1'b0; rsp_a = '0;
    start_b = 1'b0; key_b = '0; msg_b = '0; ready_en_b = 1'b0; rsp_b = '0;
    sdi_a = 1'b0; sdi_b = 1'b0; slave_ready_a = 1'b0; slave_ready_b = 1'b0;
    test_reset();
    test_load_read();
    test_timeout();
    test_reset_mid_load();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
